// File: rtl/mdu_issue_ctrl.sv
// EX-stage initiator for the multiply/divide unit: registers op/move pulses for the MDU,
// tracks its busy window, stalls dependent instructions and returns HI/LO for mfhi/mflo.
module mdu_issue_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [3:0]  IDLE_OP = 4'b1000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [3:0]       ex_mdu_op,
    input  logic [1:0]       ex_mt_sel,
    input  logic [1:0]       ex_mf_sel,
    input  logic [WIDTH-1:0] ex_srca,
    input  logic [WIDTH-1:0] ex_srcb,
    input  logic             mdu_busy,
    input  logic [WIDTH-1:0] mdu_hi,
    input  logic [WIDTH-1:0] mdu_lo,
    output logic [3:0]       mdu_op,
    output logic [1:0]       mdu_mthilo,
    output logic [WIDTH-1:0] mdu_srca,
    output logic [WIDTH-1:0] mdu_srcb,
    output logic             mdu_clr,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data,
    output logic [CNT_W-1:0] issue_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OP_PEND = 2'd1,
        BUSY    = 2'd2,
        MT_PEND = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [1:0]         mthilo_q, mthilo_d;
    logic [WIDTH-1:0]   srca_q, srca_d;
    logic [WIDTH-1:0]   srcb_q, srcb_d;
    logic               clr_q, clr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic arith_req;
    logic mt_req;
    logic mf_req;
    logic req;

    assign arith_req = ex_valid & ~ex_mdu_op[3];
    assign mt_req    = ex_valid & ex_mt_sel[0];
    assign mf_req    = ex_valid & ex_mf_sel[0];
    assign req       = arith_req | mt_req | mf_req;

    // Any MDU request must wait while an earlier one is still in flight; a flush cancels it.
    assign stall   = req & ((state_q != IDLE) | mdu_busy) & ~flush;
    assign mf_data = (ex_mf_sel == 2'b11) ? mdu_hi : mdu_lo;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        op_d     = IDLE_OP;
        mthilo_d = 2'b00;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        clr_d    = 1'b0;
        cnt_d    = cnt_q;

        if (flush) begin
            state_d = IDLE;
            clr_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!mdu_busy) begin
                        if (arith_req) begin
                            op_d    = ex_mdu_op;
                            srca_d  = ex_srca;
                            srcb_d  = ex_srcb;
                            cnt_d   = cnt_q + 1'b1;
                            state_d = OP_PEND;
                        end else if (mt_req) begin
                            mthilo_d = ex_mt_sel;
                            srca_d   = ex_srca;
                            state_d  = MT_PEND;
                        end
                    end
                end
                OP_PEND: state_d = BUSY;
                BUSY:    if (!mdu_busy) state_d = IDLE;
                MT_PEND: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= IDLE_OP;
            mthilo_q <= 2'b00;
            srca_q   <= '0;
            srcb_q   <= '0;
            clr_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mthilo_q <= mthilo_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            clr_q    <= clr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mdu_op     = op_q;
    assign mdu_mthilo = mthilo_q;
    assign mdu_srca   = srca_q;
    assign mdu_srcb   = srcb_q;
    assign mdu_clr    = clr_q;
    assign issue_cnt  = cnt_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: a small behavioural MDU answers the issued ops, a per-cycle
// vector table walks the main scenarios, and hand sequences cover async reset and counter wrap.
module tb_mdu_issue_ctrl;

    localparam logic [3:0] OP_MULT = 4'b0001;   // signed multiply in the bench MDU model
    localparam logic [3:0] OP_DIVU = 4'b0011;   // unsigned divide in the bench MDU model
    localparam logic [3:0] OP_NONE = 4'b1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_mdu_op;
    logic [1:0]  ex_mt_sel;
    logic [1:0]  ex_mf_sel;
    logic [31:0] ex_srca;
    logic [31:0] ex_srcb;
    logic        mdu_busy;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;
    logic [3:0]  mdu_op;
    logic [1:0]  mdu_mthilo;
    logic [31:0] mdu_srca;
    logic [31:0] mdu_srcb;
    logic        mdu_clr;
    logic        stall;
    logic [31:0] mf_data;
    logic [15:0] issue_cnt;

    // Second instance with a 2-bit counter and an always-idle MDU, for the wrap check.
    logic        w_valid;
    logic [3:0]  w_op;
    logic [1:0]  w_mthilo;
    logic [31:0] w_srca;
    logic [31:0] w_srcb;
    logic        w_clr;
    logic        w_stall;
    logic [31:0] w_mf_data;
    logic [1:0]  w_issue_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mdu_issue_ctrl #(.WIDTH(32), .IDLE_OP(4'b1000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid),
        .ex_mdu_op(ex_mdu_op), .ex_mt_sel(ex_mt_sel), .ex_mf_sel(ex_mf_sel),
        .ex_srca(ex_srca), .ex_srcb(ex_srcb), .mdu_busy(mdu_busy),
        .mdu_hi(mdu_hi), .mdu_lo(mdu_lo), .mdu_op(mdu_op), .mdu_mthilo(mdu_mthilo),
        .mdu_srca(mdu_srca), .mdu_srcb(mdu_srcb), .mdu_clr(mdu_clr), .stall(stall),
        .mf_data(mf_data), .issue_cnt(issue_cnt)
    );

    mdu_issue_ctrl #(.WIDTH(32), .IDLE_OP(4'b1000), .CNT_W(2)) dut_wrap (
        .clk(clk), .reset(reset), .flush(1'b0), .ex_valid(w_valid),
        .ex_mdu_op(ex_mdu_op), .ex_mt_sel(2'b00), .ex_mf_sel(2'b00),
        .ex_srca(ex_srca), .ex_srcb(ex_srcb), .mdu_busy(1'b0),
        .mdu_hi(32'h0), .mdu_lo(32'h0), .mdu_op(w_op), .mdu_mthilo(w_mthilo),
        .mdu_srca(w_srca), .mdu_srcb(w_srcb), .mdu_clr(w_clr), .stall(w_stall),
        .mf_data(w_mf_data), .issue_cnt(w_issue_cnt)
    );

    // Behavioural MDU: samples MDUOp, is busy 5 (mult) or 10 (div) cycles starting the
    // following cycle, commits HI/LO on the edge busy falls; clr kills the op in flight.
    int unsigned busy_cnt;
    logic [31:0] hi_r, lo_r;
    logic [63:0] res_r;

    function automatic logic [63:0] mdu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op == OP_DIVU) return {a % b, a / b};
        return sa * sb;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_cnt <= 0;
            hi_r     <= '0;
            lo_r     <= '0;
            res_r    <= '0;
        end else if (mdu_clr) begin
            busy_cnt <= 0;
        end else begin
            if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) {hi_r, lo_r} <= res_r;
            end else if (!mdu_op[3]) begin
                res_r    <= mdu_calc(mdu_op, mdu_srca, mdu_srcb);
                busy_cnt <= (mdu_op == OP_DIVU) ? 10 : 5;
            end
            if (mdu_mthilo == 2'b11)      hi_r <= mdu_srca;
            else if (mdu_mthilo == 2'b01) lo_r <= mdu_srca;
        end
    end

    assign mdu_busy = (busy_cnt != 0);
    assign mdu_hi   = hi_r;
    assign mdu_lo   = lo_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One record per clock cycle: inputs driven that cycle, outputs expected in that cycle.
    typedef struct {
        logic [31:0] valid, op, mt, mf, a, b, fl;
        logic [31:0] x_stall, x_op, x_mthilo, x_clr, x_cnt, chk_mf, x_mf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [31:0] valid, op, mt, mf, a, b, fl,
                       input logic [31:0] x_stall, x_op, x_mthilo, x_clr, x_cnt, chk_mf, x_mf);
        vec_t t;
        t.valid = valid; t.op = op; t.mt = mt; t.mf = mf; t.a = a; t.b = b; t.fl = fl;
        t.x_stall = x_stall; t.x_op = x_op; t.x_mthilo = x_mthilo; t.x_clr = x_clr;
        t.x_cnt = x_cnt; t.chk_mf = chk_mf; t.x_mf = x_mf;
        tbl.push_back(t);
    endtask

    int w_exp[11] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // mult 3 * -2, mflo waits out OP_PEND + 5 busy + drain cycle, then mflo/mfhi
        add(1, OP_MULT, 0, 0, 3, 32'hFFFF_FFFE, 0,  0, OP_NONE, 0, 0, 0, 0, 0);
        add(1, OP_NONE, 0, 1, 0, 0, 0,              1, OP_MULT, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) add(1, OP_NONE, 0, 1, 0, 0, 0, 1, OP_NONE, 0, 0, 1, 0, 0);
        add(1, OP_NONE, 0, 1, 0, 0, 0,              0, OP_NONE, 0, 0, 1, 1, 32'hFFFF_FFFA);
        add(1, OP_NONE, 0, 3, 0, 0, 0,              0, OP_NONE, 0, 0, 1, 1, 32'hFFFF_FFFF);
        // divu 7 / 2: 10 busy cycles, then mfhi = remainder 1, mflo = quotient 3
        add(1, OP_DIVU, 0, 0, 7, 2, 0,              0, OP_NONE, 0, 0, 1, 0, 0);
        add(1, OP_NONE, 0, 3, 0, 0, 0,              1, OP_DIVU, 0, 0, 2, 0, 0);
        for (int i = 0; i < 11; i++) add(1, OP_NONE, 0, 3, 0, 0, 0, 1, OP_NONE, 0, 0, 2, 0, 0);
        add(1, OP_NONE, 0, 3, 0, 0, 0,              0, OP_NONE, 0, 0, 2, 1, 1);
        add(1, OP_NONE, 0, 1, 0, 0, 0,              0, OP_NONE, 0, 0, 2, 1, 3);
        // mtlo 0x1234, dependent mflo stalls exactly one cycle
        add(1, OP_NONE, 1, 0, 32'h1234, 0, 0,       0, OP_NONE, 0, 0, 2, 0, 0);
        add(1, OP_NONE, 0, 1, 0, 0, 0,              1, OP_NONE, 1, 0, 2, 0, 0);
        add(1, OP_NONE, 0, 1, 0, 0, 0,              0, OP_NONE, 0, 0, 2, 1, 32'h1234);
        // mult 5 * 6 killed by a flush during OP_PEND; HI/LO keep their old values
        add(1, OP_MULT, 0, 0, 5, 6, 0,              0, OP_NONE, 0, 0, 2, 0, 0);
        add(0, OP_NONE, 0, 0, 0, 0, 1,              0, OP_MULT, 0, 0, 3, 0, 0);
        add(1, OP_NONE, 0, 1, 0, 0, 0,              1, OP_NONE, 0, 1, 3, 0, 0);
        add(1, OP_NONE, 0, 1, 0, 0, 0,              0, OP_NONE, 0, 0, 3, 1, 32'h1234);
        add(1, OP_NONE, 0, 3, 0, 0, 0,              0, OP_NONE, 0, 0, 3, 1, 1);
        // mult presented together with flush is discarded: no issue, count unchanged
        add(1, OP_MULT, 0, 0, 9, 9, 1,              0, OP_NONE, 0, 0, 3, 0, 0);
        add(0, OP_NONE, 0, 0, 0, 0, 0,              0, OP_NONE, 0, 1, 3, 0, 0);
        // back-to-back mult 2*3 then 4*5: second issues once the first has drained
        add(1, OP_MULT, 0, 0, 2, 3, 0,              0, OP_NONE, 0, 0, 3, 0, 0);
        add(1, OP_MULT, 0, 0, 4, 5, 0,              1, OP_MULT, 0, 0, 4, 0, 0);
        for (int i = 0; i < 6; i++) add(1, OP_MULT, 0, 0, 4, 5, 0, 1, OP_NONE, 0, 0, 4, 0, 0);
        add(1, OP_MULT, 0, 0, 4, 5, 0,              0, OP_NONE, 0, 0, 4, 0, 0);
        add(1, OP_NONE, 0, 1, 0, 0, 0,              1, OP_MULT, 0, 0, 5, 0, 0);
        for (int i = 0; i < 6; i++) add(1, OP_NONE, 0, 1, 0, 0, 0, 1, OP_NONE, 0, 0, 5, 0, 0);
        add(1, OP_NONE, 0, 1, 0, 0, 0,              0, OP_NONE, 0, 0, 5, 1, 20);
        // arith and mt together: arith wins, MTHILO stays 00
        add(1, OP_MULT, 1, 0, 1, 1, 0,              0, OP_NONE, 0, 0, 5, 0, 0);
        add(0, OP_NONE, 0, 0, 0, 0, 0,              0, OP_MULT, 0, 0, 6, 0, 0);
        add(1, OP_NONE, 0, 1, 0, 0, 0,              1, OP_NONE, 0, 0, 6, 0, 0);
        // sel codes 10 are not requests, so no stall even while busy
        add(1, OP_NONE, 2, 2, 0, 0, 0,              0, OP_NONE, 0, 0, 6, 0, 0);

        reset = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_mdu_op = OP_NONE;
        ex_mt_sel = 2'b00; ex_mf_sel = 2'b00; ex_srca = '0; ex_srcb = '0; w_valid = 1'b0;
        #12;
        check("rst mdu_op", 32'(mdu_op), 32'(OP_NONE));
        check("rst mthilo", 32'(mdu_mthilo), 0);
        check("rst srca", mdu_srca, 0);
        check("rst srcb", mdu_srcb, 0);
        check("rst clr", 32'(mdu_clr), 0);
        check("rst cnt", 32'(issue_cnt), 0);
        check("rst stall", 32'(stall), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            ex_valid  = tbl[i].valid[0];
            ex_mdu_op = tbl[i].op[3:0];
            ex_mt_sel = tbl[i].mt[1:0];
            ex_mf_sel = tbl[i].mf[1:0];
            ex_srca   = tbl[i].a;
            ex_srcb   = tbl[i].b;
            flush     = tbl[i].fl[0];
            @(negedge clk);
            check($sformatf("v%0d stall", i), 32'(stall), tbl[i].x_stall);
            check($sformatf("v%0d mdu_op", i), 32'(mdu_op), tbl[i].x_op);
            check($sformatf("v%0d mthilo", i), 32'(mdu_mthilo), tbl[i].x_mthilo);
            check($sformatf("v%0d clr", i), 32'(mdu_clr), tbl[i].x_clr);
            check($sformatf("v%0d cnt", i), 32'(issue_cnt), tbl[i].x_cnt);
            if (tbl[i].chk_mf[0]) check($sformatf("v%0d mf_data", i), mf_data, tbl[i].x_mf);
        end

        // Async reset while the MDU is mid-op: outputs clear without a clock edge
        #1;
        ex_valid = 1'b1; ex_mdu_op = OP_NONE; ex_mt_sel = 2'b00; ex_mf_sel = 2'b01; flush = 1'b0;
        #1;
        check("busy mflo stall", 32'(stall), 1);
        reset = 1'b1;
        #1;
        check("arst mdu_op", 32'(mdu_op), 32'(OP_NONE));
        check("arst stall", 32'(stall), 0);
        check("arst cnt", 32'(issue_cnt), 0);
        check("arst mthilo", 32'(mdu_mthilo), 0);
        check("arst clr", 32'(mdu_clr), 0);
        @(posedge clk); #1;
        reset = 1'b0; ex_valid = 1'b0; ex_mf_sel = 2'b00;

        // Counter wrap on the 2-bit instance: one issue every three cycles
        w_valid = 1'b1; ex_mdu_op = OP_MULT; ex_srca = 32'd1; ex_srcb = 32'd1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            check($sformatf("wrap c%0d cnt", k), 32'(w_issue_cnt), w_exp[k]);
            @(posedge clk); #1;
        end
        w_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
